// File: rtl/apb4_bridge_pkg.sv
// rtl/apb4_bridge_pkg.sv - shared types and helpers for the APB4 register bridge
package apb4_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Widest strobe vector the expansion helper handles; callers truncate the result.
    localparam int MAX_STRB_W = 128;

    // Channel-select width; a single channel still gets one index bit.
    function automatic int ch_sel_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Replicate every byte strobe across its eight data bits.
    function automatic logic [MAX_STRB_W*8-1:0] strb_to_biten(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_STRB_W*8-1:0] biten;
        biten = '0;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            biten[i*8 +: 8] = {8{strb[i]}};
        end
        return biten;
    endfunction

endpackage

// File: rtl/apb4_reg_bridge_if.sv
// rtl/apb4_reg_bridge_if.sv - APB4 port bundle between fabric and bridge
interface apb4_reg_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_ch_decoder.sv
// rtl/apb4_ch_decoder.sv - channel index and decode-error logic for the bridge
module apb4_ch_decoder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int N_CH        = 4,
    parameter int CH_AW       = 8,
    parameter int CH_SEL_W    = 2,
    parameter int SECURE_ONLY = 0
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [2:0]            pprot,
    output logic [CH_SEL_W-1:0]   ch,
    output logic                  dec_err
);
    logic idx_bad;
    logic high_bad;
    logic prot_bad;
    logic unused_prot;

    assign ch       = paddr[CH_AW +: CH_SEL_W];
    assign idx_bad  = 32'(ch) >= 32'(N_CH);
    // Any address bit above the channel field means the access is outside the bridge window.
    assign high_bad = (paddr >> (CH_AW + CH_SEL_W)) != '0;
    assign prot_bad = (SECURE_ONLY != 0) && pprot[1];
    assign dec_err  = idx_bad | high_bad | prot_bad;

    // Only the non-secure attribute matters here.
    assign unused_prot = &{1'b0, pprot[2], pprot[0]};
endmodule

// File: rtl/apb4_reg_bridge.sv
// rtl/apb4_reg_bridge.sv - APB4 completer fanning out to N_CH register-bank channels
module apb4_reg_bridge
    import apb4_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int N_CH        = 4,
    parameter int CH_AW       = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int SECURE_ONLY = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    apb4_reg_bridge_if.slave           apb,
    output logic [N_CH-1:0]            bus_req,
    output logic                       bus_req_is_wr,
    output logic [CH_AW-1:0]           bus_addr,
    output logic [DATA_WIDTH-1:0]      bus_wr_data,
    output logic [DATA_WIDTH-1:0]      bus_wr_biten,
    input  logic [N_CH-1:0]            bus_ready,
    input  logic [N_CH-1:0]            bus_err,
    input  logic [N_CH*DATA_WIDTH-1:0] bus_rd_data
);
    localparam int CH_SEL_W = ch_sel_w(N_CH);
    localparam int CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_e                  state_q, state_d;
    logic [CH_SEL_W-1:0]     dec_ch;
    logic                    dec_err;
    logic [CH_SEL_W-1:0]     ch_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    setup;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    timeout_hit;
    logic [DATA_WIDTH-1:0]   wr_biten;
    logic                    resp_err_d;
    logic [DATA_WIDTH-1:0]   resp_data_d;

    apb4_ch_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .N_CH        (N_CH),
        .CH_AW       (CH_AW),
        .CH_SEL_W    (CH_SEL_W),
        .SECURE_ONLY (SECURE_ONLY)
    ) u_dec (
        .paddr   (apb.paddr),
        .pprot   (apb.pprot),
        .ch      (dec_ch),
        .dec_err (dec_err)
    );

    assign setup       = apb.psel & ~apb.penable;
    assign sel_ready   = bus_ready[ch_q];
    assign sel_err     = bus_err[ch_q];
    assign sel_rdata   = bus_rd_data[ch_q*DATA_WIDTH +: DATA_WIDTH];
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign wr_biten    = DATA_WIDTH'(strb_to_biten(MAX_STRB_W'(apb.pstrb)));

    // Next state plus the response that will be presented if RESP is entered.
    always_comb begin
        state_d     = state_q;
        resp_err_d  = 1'b0;
        resp_data_d = '0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    if (dec_err) begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (sel_ready) begin
                    state_d     = RESP;
                    resp_err_d  = sel_err;
                    resp_data_d = (sel_err || bus_req_is_wr) ? '0 : sel_rdata;
                end else if (state_q == WAIT && timeout_hit) begin
                    state_d    = RESP;
                    resp_err_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered APB response / request pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
            bus_req     <= '0;
        end else begin
            state_q     <= state_d;
            apb.pready  <= (state_d == RESP);
            apb.pslverr <= resp_err_d;
            apb.prdata  <= resp_data_d;
            bus_req     <= (state_d == REQ) ? (N_CH'(1) << dec_ch) : '0;
        end
    end

    // Transfer attributes are captured once at setup and held until the next setup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q          <= '0;
            bus_req_is_wr <= 1'b0;
            bus_addr      <= '0;
            bus_wr_data   <= '0;
            bus_wr_biten  <= '0;
        end else if (state_q == IDLE && setup) begin
            ch_q          <= dec_ch;
            bus_req_is_wr <= apb.pwrite;
            bus_addr      <= apb.paddr[CH_AW-1:0];
            bus_wr_data   <= apb.pwdata;
            bus_wr_biten  <= apb.pwrite ? wr_biten : '0;
        end
    end

    // Wait-state counter: zero outside WAIT, counts up and saturates inside it.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != WAIT) begin
            cnt_q <= '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule
